// File: rtl/decoder_arb_pkg.sv
// decoder_arb_pkg
// Shared types and sizes for the 8-way round-robin select arbiter
// (decoder_rr_arbiter) and its sub-blocks.
//   N_REQ       : number of requesters / decoded select lines
//   IDX_W       : width of the binary owner index
//   arb_state_e : arbiter state (IDLE, GRANT)
//   idx_t       : binary requester index
package decoder_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [IDX_W-1:0] idx_t;

  // Next index in round-robin order; 7 wraps to 0 through the natural
  // modulo of the index width.
  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// decoder_3to8
// 3-to-8 one-hot select decoder with enable.
// Ports:
//   idx : binary select index
//   en  : when low, all outputs are zero
//   dec : one-hot decode of idx, or all-zero when disabled
module decoder_3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] dec
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign dec[gi] = en & (idx == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority search. Finds the first set request
// bit searching upward from ptr, wrapping from the top index back to 0.
// Ports:
//   req     : request vector
//   ptr     : highest-priority index for this search
//   winner  : index of the selected requester (meaningless if any_req=0)
//   any_req : high when at least one request bit is set
module rr_pick
  import decoder_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Rotate the request vector so that bit 0 corresponds to ptr; a plain
  // lowest-bit-first search on the rotated vector then gives the
  // round-robin order, and the offset is added back onto ptr.
  logic [N_REQ-1:0] rot;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      idx_t src;
      assign src     = ptr + idx_t'(gi);
      assign rot[gi] = req[src];
    end
  endgenerate

  idx_t off;

  always_comb begin
    off = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = idx_t'(i);
      end
    end
  end

  assign winner  = ptr + off;
  assign any_req = |req;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
// 8-way round-robin arbiter that owns a single one-hot select resource.
// An owner keeps the grant while its request stays high; on release one
// all-zero grant cycle separates it from the next owner, and priority
// rotates to the index after the previous owner.
//
// Optional feature (macro ARB_TIMEOUT_EN): a hold counter forces release
// after MAX_HOLD consecutive grant cycles and pulses timeout for one cycle.
// With the macro undefined the timeout port and counter do not exist.
//
// Parameters:
//   MAX_HOLD  : grant cycles before forced release (2..255), timeout build only
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request per requester
//   gnt       : one-hot grant, zero when idle
//   gnt_idx   : binary index of current/last owner
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse on forced release (ARB_TIMEOUT_EN only)
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
      $error("decoder_rr_arbiter: MAX_HOLD must be within 2..255");
    end
  endgenerate

  arb_state_e state_reg, state_next;
  idx_t       idx_reg, idx_next;
  logic       valid_reg, valid_next;
  idx_t       ptr_reg, ptr_next;

  idx_t       winner;
  logic       any_req;

`ifdef ARB_TIMEOUT_EN
  // The counter holds the number of completed grant cycles; the release
  // decision is taken on the edge that would make it reach MAX_HOLD.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_reg, cnt_next;
  logic       timeout_reg, timeout_next;
`endif

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      ptr_reg     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      ptr_reg     <= ptr_next;
`ifdef ARB_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    ptr_next     = ptr_reg;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        // Arbitration only happens here, so every owner change passes
        // through at least one cycle with gnt all-zero.
        if (any_req) begin
          state_next = GRANT;
          idx_next   = winner;
          valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end

      GRANT: begin
        if (!req[idx_reg]) begin
          // Voluntary release takes precedence over the hold limit.
          state_next = IDLE;
          valid_next = 1'b0;
          ptr_next   = idx_inc(idx_reg);
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_reg == HOLD_LAST) begin
          state_next   = IDLE;
          valid_next   = 1'b0;
          ptr_next     = idx_inc(idx_reg);
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // gnt_idx keeps the last owner after release; the decoder's enable
  // forces the one-hot lines to zero whenever no grant is held.
  decoder_3to8 u_dec (
    .idx (idx_reg),
    .en  (valid_reg),
    .dec (gnt)
  );

  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_reg;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter
// Directed bench for decoder_rr_arbiter: reset, idle, single grant and
// release, pointer advance, async reset mid-grant, full round-robin order,
// wrap-around, single requester re-grant, one-cycle request, and the hold
// limit (ARB_TIMEOUT_EN, MAX_HOLD=4) or indefinite hold (default build).
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  decoder_rr_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic exp_grant(input string tag, input int idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    chk({tag, ".gnt"},   32'(gnt),       32'(oh));
    chk({tag, ".idx"},   32'(gnt_idx),   32'(idx));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic exp_idle(input string tag, input int idx);
    chk({tag, ".gnt"},   32'(gnt),       32'd0);
    chk({tag, ".idx"},   32'(gnt_idx),   32'(idx));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    exp_idle("reset", 0);
`ifdef ARB_TIMEOUT_EN
    chk("reset.timeout", 32'(timeout), 32'd0);
`endif
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      exp_idle("idle", 0);
    end

    // Single grant to requester 4, held, then released.
    req = 8'h10;
    step();
    exp_grant("g4", 4);
    req = 8'h1F;  // other bits are ignored while 4 owns the grant
    for (int i = 0; i < 3; i++) begin
      step();
      exp_grant("g4_hold", 4);
    end
    req = 8'h00;
    step();
    exp_idle("g4_rel", 4);
    step();
    exp_idle("g4_idle", 4);

    // ptr is now 5: with bits 0 and 5 requesting, 5 wins.
    req = 8'h21;
    step();
    exp_grant("ptr5", 5);

    // Asynchronous reset in the middle of a grant.
    #2;
    rst_n = 1'b0;
    #1;
    exp_idle("async_rst", 0);
`ifdef ARB_TIMEOUT_EN
    chk("async_rst.timeout", 32'(timeout), 32'd0);
`endif
    step();
    exp_idle("rst_hold", 0);

    // Full round robin from ptr=0: hold two cycles, drop for one.
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      int e;
      e = k % 8;
      step();
      exp_grant("rr", e);
      step();
      exp_grant("rr_hold", e);
      req = 8'hFF & ~(8'h01 << e);
      step();
      exp_idle("rr_bubble", e);
      req = 8'hFF;
    end
    req = 8'h00;
    step();
    exp_idle("rr_end", 0);

    // Move ptr to 7 via a grant to 6, then test 7 -> 0 wrap-around.
    req = 8'h40;
    step();
    exp_grant("g6", 6);
    req = 8'h00;
    step();
    exp_idle("g6_rel", 6);
    req = 8'h81;
    step();
    exp_grant("wrap7", 7);
    req = 8'h01;
    step();
    exp_idle("wrap_bubble", 7);
    step();
    exp_grant("wrap0", 0);
    req = 8'h00;
    step();
    exp_idle("wrap_rel", 0);

    // Single requester re-granted after the bubble regardless of ptr.
    req = 8'h04;
    step();
    exp_grant("solo", 2);
    req = 8'h00;
    step();
    exp_idle("solo_rel", 2);
    req = 8'h04;
    step();
    exp_grant("solo_again", 2);
    req = 8'h00;
    step();
    exp_idle("solo_rel2", 2);

    // One-cycle request: one grant cycle, then release.
    req = 8'h08;
    step();
    req = 8'h00;
    exp_grant("pulse", 3);
    step();
    exp_idle("pulse_rel", 3);

    // Long hold by requester 1.
    req = 8'h02;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      exp_grant("to_hold", 1);
      chk("to_hold.timeout", 32'(timeout), 32'd0);
    end
    step();
    exp_idle("to_force", 1);
    chk("to_force.timeout", 32'(timeout), 32'd1);
    step();
    exp_grant("to_regrant", 1);
    chk("to_regrant.timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_grant("vol_hold", 1);
    end
    // Voluntary release on the same edge the limit would be reached.
    req = 8'h00;
    step();
    exp_idle("vol_rel", 1);
    chk("vol_rel.timeout", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      exp_grant("long_hold", 1);
    end
    req = 8'h00;
    step();
    exp_idle("long_rel", 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
